aes128_iter_core: RTL and testbench

//  Low-area iterative AES-128 (FIPS-197) engine, one round per clock.

---
 rtl/aes_pkg.sv | 95 +++++++++
 rtl/aes_sbox.sv | 13 +
 rtl/aes128_iter_core.sv | 192 +++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants: S-boxes, round constants, GF(2^8) helpers.
// Phase encoding for the iterative round controller.
package aes_pkg;

  typedef enum logic [2:0] {
    PH_LOAD,
    PH_ENC,
    PH_TURN,
    PH_DEC,
    PH_DONE
  } phase_e;

  localparam logic [5:0] ST_LOAD     = 6'd0;
  localparam logic [5:0] ST_FIRST    = 6'd1;
  localparam logic [5:0] ST_LAST_ENC = 6'd10;
  localparam logic [5:0] ST_TURN     = 6'd11;
  localparam logic [5:0] ST_FIRST_DEC = 6'd12;
  localparam logic [5:0] ST_LAST_DEC = 6'd21;
  localparam logic [5:0] ST_DONE     = 6'd22;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic logic [7:0] rcon(input logic [5:0] i);
    logic [7:0] r;
    unique case (i)
      6'd1:    r = 8'h01;
      6'd2:    r = 8'h02;
      6'd3:    r = 8'h04;
      6'd4:    r = 8'h08;
      6'd5:    r = 8'h10;
      6'd6:    r = 8'h20;
      6'd7:    r = 8'h40;
      6'd8:    r = 8'h80;
      6'd9:    r = 8'h1b;
      6'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES substitution, forward or inverse.
// Direction picked per lookup so one instance serves both phases.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic       inv_i,
  output logic [7:0] y_o
);

  assign y_o = inv_i ? INV_SBOX[a_i] : SBOX[a_i];

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128: encrypt in 10 rounds, then decrypt back.
// One round per clock; a run is started only by releasing reset.
module aes128_iter_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic [5:0]   state,
  output logic         sel
);

  logic [127:0] data_q, data_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] out_q, out_d;
  logic [5:0]   state_q, state_d;
  logic         sel_q, sel_d;
  phase_e       phase;

  logic [127:0] sb;
  logic [31:0]  kw, rot, sw, rcw;
  logic [5:0]   rc_idx;
  logic [31:0]  e0, e1, e2, e3;
  logic [31:0]  d0, d1, d2, d3;
  logic [127:0] rk_n;
  logic [127:0] enc_sr, enc_mx;
  logic [127:0] dec_t, dec_mx;

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
            gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
            gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
            gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
            gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
            gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s,
                                               input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = inv ? inv_mix_col(s[127-32*c -: 32])
                              : mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // Byte substitution commutes with the row shift, so sboxes sit on data_q.
  for (genvar i = 0; i < 16; i++) begin : g_dsb
    aes_sbox u_sb (
      .a_i   (data_q[127-8*i -: 8]),
      .inv_i (sel_q),
      .y_o   (sb[127-8*i -: 8])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_sb (
      .a_i   (rot[31-8*j -: 8]),
      .inv_i (1'b0),
      .y_o   (sw[31-8*j -: 8])
    );
  end

  // Reverse key step needs the recovered w3 before SubWord.
  assign kw     = sel_q ? (rk_q[31:0] ^ rk_q[63:32]) : rk_q[31:0];
  assign rot    = {kw[23:0], kw[31:24]};
  assign rc_idx = sel_q ? (ST_DONE - state_q) : state_q;
  assign rcw    = {rcon(rc_idx), 24'h0};

  assign e0 = rk_q[127:96] ^ sw ^ rcw;
  assign e1 = rk_q[95:64] ^ e0;
  assign e2 = rk_q[63:32] ^ e1;
  assign e3 = rk_q[31:0] ^ e2;

  assign d3 = rk_q[31:0] ^ rk_q[63:32];
  assign d2 = rk_q[63:32] ^ rk_q[95:64];
  assign d1 = rk_q[95:64] ^ rk_q[127:96];
  assign d0 = rk_q[127:96] ^ sw ^ rcw;

  assign rk_n = sel_q ? {d0, d1, d2, d3} : {e0, e1, e2, e3};

  assign enc_sr = shift_rows(sb);
  assign enc_mx = mix_columns(enc_sr, 1'b0);
  assign dec_t  = inv_shift_rows(sb) ^ rk_n;
  assign dec_mx = mix_columns(dec_t, 1'b1);

  always_comb begin
    phase = PH_DONE;
    unique case (1'b1)
      (state_q == ST_LOAD):
        phase = PH_LOAD;
      (state_q >= ST_FIRST && state_q <= ST_LAST_ENC):
        phase = PH_ENC;
      (state_q == ST_TURN):
        phase = PH_TURN;
      (state_q >= ST_FIRST_DEC && state_q <= ST_LAST_DEC):
        phase = PH_DEC;
      default:
        phase = PH_DONE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    rk_d    = rk_q;
    out_d   = out_q;
    state_d = state_q;
    sel_d   = sel_q;
    unique case (phase)
      PH_LOAD: begin
        data_d  = in ^ key;
        rk_d    = key;
        state_d = ST_FIRST;
      end
      PH_ENC: begin
        rk_d    = rk_n;
        data_d  = (state_q == ST_LAST_ENC) ? (enc_sr ^ rk_n)
                                           : (enc_mx ^ rk_n);
        if (state_q == ST_LAST_ENC) out_d = enc_sr ^ rk_n;
        state_d = state_q + 6'd1;
      end
      PH_TURN: begin
        sel_d   = 1'b1;
        data_d  = data_q ^ rk_q;
        state_d = ST_FIRST_DEC;
      end
      PH_DEC: begin
        rk_d    = rk_n;
        data_d  = (state_q == ST_LAST_DEC) ? dec_t : dec_mx;
        if (state_q == ST_LAST_DEC) out_d = dec_t;
        state_d = state_q + 6'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      rk_q    <= '0;
      out_q   <= '0;
      state_q <= ST_LOAD;
      sel_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      rk_q    <= rk_d;
      out_q   <= out_d;
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign out   = out_q;
  assign state = state_q;
  assign sel   = sel_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: FIPS-197 vectors, reset abort,
// input changes after load and the terminal hold.
module tb_aes128_iter_core;

  logic         clk;
  logic         rst_v;
  logic [127:0] in_v;
  logic [127:0] key_v;
  logic [127:0] out_v;
  logic [5:0]   state_v;
  logic         sel_v;

  int checks;
  int errors;

  typedef struct {
    int           cyc;
    logic [5:0]   st;
    logic [127:0] val;
    logic         sel;
  } exp_t;

  exp_t sb[$];

  logic [127:0] pts  [3];
  logic [127:0] keys [3];
  logic [127:0] cts  [3];

  aes128_iter_core dut (
    .clk   (clk),
    .rst   (rst_v),
    .in    (in_v),
    .key   (key_v),
    .out   (out_v),
    .state (state_v),
    .sel   (sel_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_run(input logic [127:0] p, input logic [127:0] k);
    rst_v = 1'b0;
    in_v  = p;
    key_v = k;
    step();
    rst_v = 1'b1;
  endtask

  task automatic push_run(input logic [127:0] p, input logic [127:0] c);
    sb.push_back('{11, 6'd11, c, 1'b0});
    sb.push_back('{22, 6'd22, p, 1'b1});
  endtask

  task automatic test_reset();
    rst_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (state_v !== 6'd0 || out_v !== 128'd0 || sel_v !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: state=%0d out=%h sel=%b, want 0/0/0",
                 i, state_v, out_v, sel_v);
      end
    end
  endtask

  task automatic test_vectors();
    exp_t e;
    for (int v = 0; v < 3; v++) begin
      begin_run(pts[v], keys[v]);
      push_run(pts[v], cts[v]);
      for (int c = 1; c <= 24 && sb.size() > 0; c++) begin
        step();
        if (c == sb[0].cyc) begin
          e = sb.pop_front();
          checks++;
          if (state_v !== e.st || out_v !== e.val || sel_v !== e.sel) begin
            errors++;
            $display("FAIL vec%0d cyc%0d: state=%0d out=%h sel=%b, want %0d %h %b",
                     v, c, state_v, out_v, sel_v, e.st, e.val, e.sel);
          end
        end
      end
    end
  endtask

  task automatic test_midrun_reset();
    exp_t e;
    int   n;
    begin_run(pts[1], keys[1]);
    n = 0;
    while (state_v !== 6'd5 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (state_v !== 6'd5) begin
      errors++;
      $display("FAIL midrun_reach: state=%0d, want 5", state_v);
    end
    rst_v = 1'b0;
    #1;
    checks++;
    if (state_v !== 6'd0 || out_v !== 128'd0 || sel_v !== 1'b0) begin
      errors++;
      $display("FAIL midrun_abort: state=%0d out=%h sel=%b, want 0/0/0",
               state_v, out_v, sel_v);
    end
    step();
    checks++;
    if (state_v !== 6'd0 || out_v !== 128'd0 || sel_v !== 1'b0) begin
      errors++;
      $display("FAIL midrun_held: state=%0d out=%h sel=%b, want 0/0/0",
               state_v, out_v, sel_v);
    end
    rst_v = 1'b1;
    push_run(pts[1], cts[1]);
    for (int c = 1; c <= 24 && sb.size() > 0; c++) begin
      step();
      if (c == sb[0].cyc) begin
        e = sb.pop_front();
        checks++;
        if (state_v !== e.st || out_v !== e.val || sel_v !== e.sel) begin
          errors++;
          $display("FAIL rerun cyc%0d: state=%0d out=%h sel=%b, want %0d %h %b",
                   c, state_v, out_v, sel_v, e.st, e.val, e.sel);
        end
      end
    end
  endtask

  task automatic test_input_change();
    exp_t e;
    begin_run(pts[0], keys[0]);
    push_run(pts[0], cts[0]);
    for (int c = 1; c <= 24 && sb.size() > 0; c++) begin
      step();
      if (c == 3) begin
        in_v  = pts[1];
        key_v = keys[1];
      end
      if (c == sb[0].cyc) begin
        e = sb.pop_front();
        checks++;
        if (state_v !== e.st || out_v !== e.val || sel_v !== e.sel) begin
          errors++;
          $display("FAIL chg cyc%0d: state=%0d out=%h sel=%b, want %0d %h %b",
                   c, state_v, out_v, sel_v, e.st, e.val, e.sel);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (state_v !== 6'd22 || out_v !== pts[0] || sel_v !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: state=%0d out=%h sel=%b, want 22 %h 1",
                 i, state_v, out_v, sel_v, pts[0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_v  = 1'b0;
    in_v   = '0;
    key_v  = '0;
    pts[0]  = 128'h00112233445566778899aabbccddeeff;
    keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
    cts[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pts[1]  = 128'h6bc1bee22e409f96e93d7e117393172a;
    keys[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    cts[1]  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    pts[2]  = 128'h0;
    keys[2] = 128'h0;
    cts[2]  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_midrun_reset();
    test_input_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
